// File: rtl/mips_cp0_exception_unit.sv
// MIPS CP0 exception/interrupt controller: Status/Cause/EPC (+Count/Compare when
// CP0_TIMER_EN is defined), vectoring, ERET return and pipeline flush/redirect generation.
module mips_cp0_exception_unit #(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    NUM_IRQ    = 4,
  parameter logic [WORD_WIDTH-1:0] EXC_VECTOR = WORD_WIDTH'(32'h0000_0180)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic                  overflow_i,
  input  logic                  ex_valid_i,
  input  logic [WORD_WIDTH-1:0] ex_pc_i,
  input  logic                  eret_i,
  input  logic                  cp0_wr_en_i,
  input  logic [4:0]            cp0_wr_addr_i,
  input  logic [4:0]            cp0_rd_addr_i,
  input  logic [WORD_WIDTH-1:0] cp0_wr_data_i,
  output logic [WORD_WIDTH-1:0] cp0_rd_data_o,
  output logic                  if_flush_o,
  output logic                  id_flush_o,
  output logic                  ex_flush_o,
  output logic                  pc_redirect_o,
  output logic [WORD_WIDTH-1:0] redirect_pc_o,
  output logic                  exc_take_o,
  output logic [WORD_WIDTH-1:0] epc_o
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] EXC_INT      = 5'd0;
  localparam logic [4:0] EXC_OV       = 5'd12;

  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_e;

  state_e                state_q;
  logic                  ie_q;
  logic [NUM_IRQ-1:0]    im_q;
  logic [NUM_IRQ-1:0]    ip_q;
  logic [4:0]            exc_code_q;
  logic [WORD_WIDTH-1:0] epc_q;
  logic                  im7_q;
  logic                  ip7_q;
  logic [WORD_WIDTH-1:0] count_q;
  logic [WORD_WIDTH-1:0] compare_q;

  logic exl;
  logic int_req;
  logic exc_take;
  logic eret_take;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic unused_wr_bits;

  assign exl       = (state_q == HANDLER);
  assign wr_status = cp0_wr_en_i && (cp0_wr_addr_i == ADDR_STATUS);
  assign wr_cause  = cp0_wr_en_i && (cp0_wr_addr_i == ADDR_CAUSE);
  assign wr_epc    = cp0_wr_en_i && (cp0_wr_addr_i == ADDR_EPC);
  assign unused_wr_bits = ^cp0_wr_data_i;

  assign int_req   = ie_q & ~exl & ex_valid_i & (|({ip7_q, ip_q} & {im7_q, im_q}));
  // Reset masks the combinational outputs so an async reset silences flushes at once.
  assign exc_take  = ~reset_i & (overflow_i | int_req);
  assign eret_take = ~reset_i & eret_i & ~exc_take;

  assign exc_take_o    = exc_take;
  assign if_flush_o    = exc_take | eret_take;
  assign id_flush_o    = exc_take;
  assign ex_flush_o    = exc_take;
  assign pc_redirect_o = exc_take | eret_take;
  assign redirect_pc_o = exc_take ? EXC_VECTOR : (eret_take ? epc_q : '0);
  assign epc_o         = epc_q;

  // MTC0 lands first; the exception/ERET update of the same edge overrides it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= NORMAL;
      ie_q       <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      ip_q <= irq_i;
      if (wr_status) begin
        ie_q    <= cp0_wr_data_i[0];
        state_q <= cp0_wr_data_i[1] ? HANDLER : NORMAL;
        im_q    <= cp0_wr_data_i[8 +: NUM_IRQ];
      end
      if (wr_cause) exc_code_q <= cp0_wr_data_i[6:2];
      if (wr_epc)   epc_q      <= cp0_wr_data_i;
      if (exc_take && !exl) begin
        epc_q      <= ex_pc_i;
        exc_code_q <= overflow_i ? EXC_OV : EXC_INT;
        state_q    <= HANDLER;
      end else if (eret_take) begin
        state_q <= NORMAL;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic wr_count;
  logic wr_compare;

  assign wr_count   = cp0_wr_en_i && (cp0_wr_addr_i == ADDR_COUNT);
  assign wr_compare = cp0_wr_en_i && (cp0_wr_addr_i == ADDR_COMPARE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q   <= '0;
      compare_q <= '1;
      ip7_q     <= 1'b0;
      im7_q     <= 1'b0;
    end else begin
      count_q <= wr_count ? cp0_wr_data_i : count_q + WORD_WIDTH'(1);
      if (wr_compare) compare_q <= cp0_wr_data_i;
      if (wr_status)  im7_q     <= cp0_wr_data_i[15];
      // A Compare write acknowledges the timer even if a match lands on the same edge.
      if (wr_compare)                  ip7_q <= 1'b0;
      else if (count_q == compare_q)   ip7_q <= 1'b1;
    end
  end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign ip7_q     = 1'b0;
  assign im7_q     = 1'b0;
`endif

  always_comb begin
    logic [WORD_WIDTH-1:0] status_rd;
    logic [WORD_WIDTH-1:0] cause_rd;
    status_rd              = '0;
    status_rd[0]           = ie_q;
    status_rd[1]           = exl;
    status_rd[8 +: NUM_IRQ] = im_q;
    status_rd[15]          = im7_q;
    cause_rd               = '0;
    cause_rd[6:2]          = exc_code_q;
    cause_rd[8 +: NUM_IRQ] = ip_q;
    cause_rd[15]           = ip7_q;
    cp0_rd_data_o          = '0;
    case (cp0_rd_addr_i)
      ADDR_COUNT:   cp0_rd_data_o = count_q;
      ADDR_COMPARE: cp0_rd_data_o = compare_q;
      ADDR_STATUS:  cp0_rd_data_o = status_rd;
      ADDR_CAUSE:   cp0_rd_data_o = cause_rd;
      ADDR_EPC:     cp0_rd_data_o = epc_q;
      default:      cp0_rd_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_cp0_exception_unit.sv
// Scoreboard bench for mips_cp0_exception_unit: each driven cycle pushes its expected
// outputs, a negedge monitor pops and compares them.
module tb_mips_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq = '0;
  logic        overflow = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        eret = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        if_flush, id_flush, ex_flush, pc_redirect, exc_take;
  logic [31:0] redirect_pc, epc;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [4:0] C0 = 5'b00000; // {take, if, id, ex, redirect}
  localparam logic [4:0] CX = 5'b11111;
  localparam logic [4:0] CE = 5'b01001;

`ifdef CP0_TIMER_EN
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CMP_RST = 32'h0;
`endif

  typedef struct {
    string       tag;
    logic [4:0]  ctl;
    logic [31:0] rpc;
    logic [31:0] rd;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];

  mips_cp0_exception_unit dut (
    .clk_i(clk), .reset_i(reset), .irq_i(irq), .overflow_i(overflow),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .eret_i(eret),
    .cp0_wr_en_i(wr_en), .cp0_wr_addr_i(wr_addr), .cp0_rd_addr_i(rd_addr),
    .cp0_wr_data_i(wr_data), .cp0_rd_data_o(rd_data),
    .if_flush_o(if_flush), .id_flush_o(id_flush), .ex_flush_o(ex_flush),
    .pc_redirect_o(pc_redirect), .redirect_pc_o(redirect_pc),
    .exc_take_o(exc_take), .epc_o(epc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val({e.tag, ".ctl"}, {27'd0, exc_take, if_flush, id_flush, ex_flush, pc_redirect},
                {27'd0, e.ctl});
      if (e.ctl[0]) check_val({e.tag, ".rpc"}, redirect_pc, e.rpc);
      check_val({e.tag, ".rd"}, rd_data, e.rd);
      check_val({e.tag, ".epc"}, epc, e.epc);
    end
  end

  // Inputs are already set; push this cycle's expectations and advance past the edge.
  task automatic step(input string tag, input logic [4:0] ra, input logic [4:0] ctl,
                      input logic [31:0] rpc, input logic [31:0] rd, input logic [31:0] ep);
    exp_t e;
    rd_addr = ra;
    e.tag = tag; e.ctl = ctl; e.rpc = rpc; e.rd = rd; e.epc = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    step("rst_status", 5'd12, C0, 0, 0, 0);
    overflow = 1'b1;
    step("rst_cmp_ovmask", 5'd11, C0, 0, CMP_RST, 0);
    overflow = 1'b0; reset = 1'b0;

    // Interrupt on irq[2]
    mtc0(5'd12, 32'h0000_0F01);
    step("int_mtc0_nobypass", 5'd12, C0, 0, 0, 0);
    irq = 4'b0100; ex_valid = 1'b1; ex_pc = 32'h40;
    step("int_ip_latency", 5'd12, C0, 0, 32'h0F01, 0);
    step("int_take", 5'd13, CX, 32'h180, 32'h400, 0);
    irq = 4'b0000; ex_valid = 1'b0;
    step("int_exl_set", 5'd12, C0, 0, 32'h0F03, 32'h40);
    step("int_cause", 5'd13, C0, 0, 32'h0, 32'h40);
    eret = 1'b1;
    step("eret", 5'd14, CE, 32'h40, 32'h40, 32'h40);
    eret = 1'b0;
    step("eret_exl_clr", 5'd12, C0, 0, 32'h0F01, 32'h40);

    // Overflow together with a pending interrupt
    irq = 4'b0001; ex_valid = 1'b1; ex_pc = 32'h88;
    step("ov_pre", 5'd12, C0, 0, 32'h0F01, 32'h40);
    overflow = 1'b1;
    step("ov_take", 5'd13, CX, 32'h180, 32'h100, 32'h40);
    overflow = 1'b0; irq = 4'b0000; ex_valid = 1'b0;
    step("ov_cause", 5'd13, C0, 0, 32'h130, 32'h88);
    overflow = 1'b1; ex_pc = 32'hC4;
    step("ov_nested", 5'd12, CX, 32'h180, 32'h0F03, 32'h88);
    overflow = 1'b0;
    step("ov_nested_epc", 5'd14, C0, 0, 32'h88, 32'h88);
    step("ov_nested_code", 5'd13, C0, 0, 32'h30, 32'h88);
    eret = 1'b1; overflow = 1'b1; ex_pc = 32'h99;
    step("eret_vs_ov", 5'd12, CX, 32'h180, 32'h0F03, 32'h88);
    eret = 1'b0; overflow = 1'b0;
    step("eret_vs_ov_exl", 5'd12, C0, 0, 32'h0F03, 32'h88);
    eret = 1'b1;
    step("eret2", 5'd14, CE, 32'h88, 32'h88, 32'h88);
    eret = 1'b0;
    step("eret2_exl", 5'd12, C0, 0, 32'h0F01, 32'h88);

    // IE=0 and ex_valid=0 block interrupts
    mtc0(5'd12, 32'h0000_0F00); irq = 4'b0010; ex_valid = 1'b1; ex_pc = 32'h10;
    step("ie0_wr", 5'd12, C0, 0, 32'h0F01, 32'h88);
    step("ie0_ip", 5'd13, C0, 0, 32'h230, 32'h88);
    step("ie0_hold", 5'd12, C0, 0, 32'h0F00, 32'h88);
    mtc0(5'd12, 32'h0000_0F01); ex_valid = 1'b0;
    step("exv0_a", 5'd12, C0, 0, 32'h0F00, 32'h88);
    step("exv0_b", 5'd12, C0, 0, 32'h0F01, 32'h88);
    ex_valid = 1'b1; ex_pc = 32'h20;
    step("exv1_take", 5'd13, CX, 32'h180, 32'h230, 32'h88);
    irq = 4'b0000; ex_valid = 1'b0;
    step("exv1_epc", 5'd14, C0, 0, 32'h20, 32'h20);
    mtc0(5'd12, 32'h0000_0F01);
    step("mtc0_exl0", 5'd12, C0, 0, 32'h0F03, 32'h20);
    step("mtc0_exl0_res", 5'd12, C0, 0, 32'h0F01, 32'h20);

    // Reset in the middle of a handler
    overflow = 1'b1; ex_pc = 32'h30;
    step("hdl_enter", 5'd12, CX, 32'h180, 32'h0F01, 32'h20);
    reset = 1'b1;
    step("rst_mid_status", 5'd12, C0, 0, 32'h0, 32'h0);
    step("rst_mid_cause", 5'd13, C0, 0, 32'h0, 32'h0);
    overflow = 1'b0; reset = 1'b0;

`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'hFFFF_FFFF);
    step("tmr_cmp", 5'd13, C0, 0, 32'h0, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFE);
    step("tmr_cnt", 5'd11, C0, 0, 32'hFFFF_FFFF, 32'h0);
    step("tmr_fe", 5'd9, C0, 0, 32'hFFFF_FFFE, 32'h0);
    step("tmr_ff", 5'd9, C0, 0, 32'hFFFF_FFFF, 32'h0);
    step("tmr_wrap", 5'd9, C0, 0, 32'h0, 32'h0);
    mtc0(5'd11, 32'h0000_0005);
    step("tmr_ip7", 5'd13, C0, 0, 32'h8000, 32'h0);
    step("tmr_ip7_clr", 5'd13, C0, 0, 32'h0, 32'h0);
`else
    mtc0(5'd11, 32'hFFFF_FFFF);
    step("notmr_cmp", 5'd11, C0, 0, 32'h0, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFE);
    step("notmr_cnt", 5'd9, C0, 0, 32'h0, 32'h0);
    step("notmr_cnt2", 5'd9, C0, 0, 32'h0, 32'h0);
    step("notmr_ip7", 5'd13, C0, 0, 32'h0, 32'h0);
    step("notmr_cmp2", 5'd11, C0, 0, 32'h0, 32'h0);
`endif

    @(negedge clk); #1;
    check_val("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cp0_exception_unit.md
# mips_cp0_exception_unit

Parametrised coprocessor-0 exception/interrupt controller for the pipelined MIPS core. It is the successor to the single EPC register and overflow-only exception path. It adds N level-sensitive external interrupt channels, Status/Cause/EPC/Count/Compare registers, ERET return, and pipeline flush/redirect generation. It sits beside the hazard/forwarding control and drives the IF/ID/EX flush lines and the PC redirect mux.

## Interface
- WORD_WIDTH, 32, datapath/register width (≥16)
- NUM_IRQ, 4, external interrupt channels, legal range 1..6
- EXC_VECTOR, 32'h0000_0180, handler entry PC (WORD_WIDTH bits)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- irq  in  NUM_IRQ  level-sensitive external interrupt requests
- overflow  in  1  arithmetic overflow of the instruction in EX
- ex_valid  in  1  EX stage holds a real instruction (not a bubble)
- ex_pc  in  WORD_WIDTH  PC of the instruction in EX
- eret  in  1  ERET decoded in ID
- cp0_wr_en  in  1  MTC0 commit (MEM stage)
- cp0_wr_addr, cp0_rd_addr  in  5  CP0 register number
- cp0_wr_data  in  WORD_WIDTH  MTC0 data
- cp0_rd_data  out  WORD_WIDTH  MFC0 data (combinational)
- IF_Flush, ID_Flush, EX_Flush  out  1  stage flush requests
- pc_redirect  out  1  PC mux selects redirect_pc
- redirect_pc  out  WORD_WIDTH  EXC_VECTOR or EPC
- exc_take  out  1  exception/interrupt accepted this cycle
- EPC  out  WORD_WIDTH  exception PC register

## Operation
- Registers (addr): Count 9, Compare 11, Status 12, Cause 13, EPC 14. Other addresses read 0; writes to them are ignored.
- Status: bit0 IE, bit1 EXL, bits[8+:NUM_IRQ] IM, bit15 IM7 (timer). Other bits read 0.
- Cause: bits[6:2] ExcCode (0 = Int, 12 = Ov), bits[8+:NUM_IRQ] IP (read-only), bit15 IP7 (timer pending). Other bits read 0.
- IP is a per-cycle registered copy of irq; there is no latching, so a dropped irq clears IP the next cycle.
- int_req = IE & ~EXL & ex_valid & |({IP7,IP} & {IM7,IM}).
- exc_take = overflow | int_req. Overflow has priority: ExcCode = 12 when overflow, else 0.
- On exc_take with EXL=0: EPC←ex_pc, ExcCode updated, EXL←1.
- On exc_take with EXL=1 (overflow inside handler): EPC, ExcCode and EXL are unchanged; vector is still taken.
- exc_take also drives IF_Flush = ID_Flush = EX_Flush = 1, pc_redirect = 1, redirect_pc = EXC_VECTOR.
- eret without exc_take: IF_Flush = 1, pc_redirect = 1, redirect_pc = EPC; EXL←0 at the edge.
- eret with exc_take in the same cycle: the exception wins and eret is ignored.
- MTC0 write applies first; the exception update of the same edge is then applied on top (EPC, ExcCode, EXL override written bits).
- Count increments by 1 every cycle and wraps from all-ones to 0. An MTC0 to Count loads the written value instead of incrementing.
- Timer: IP7 sets when Count == Compare (pre-increment value). It stays set until an MTC0 to Compare, which clears it. If the set and the clear happen on the same edge, the clear wins.
- The unit has two states, NORMAL (EXL=0) and HANDLER (EXL=1):
  - NORMAL→HANDLER on exc_take.
  - HANDLER→NORMAL on a non-overridden eret, or on an MTC0 writing Status.EXL=0.

## Timing
- Reset values: Status 0, Cause 0, EPC 0, Count 0, Compare all-ones. All flush/redirect/exc_take outputs are 0.
- Flush, redirect and exc_take are combinational in the cycle of the triggering condition. Register updates occur on the following edge.
- irq→IP latency is 1 cycle, so the earliest exc_take is the cycle after irq is sampled.
- MFC0 reads the registered value; there is no bypass of a same-cycle MTC0.
- Reset asserted mid-handler returns the unit to NORMAL immediately (asynchronously) with reset values.

## Configuration
- CP0_TIMER_EN defined:
  - Count/Compare registers, IP7/IM7 and timer interrupt are present.
- CP0_TIMER_EN undefined:
  - Count/Compare read 0 and writes to them are ignored.
  - IP7 and IM7 are tied 0.
  - No timer interrupt is generated.

## Test plan
- Reset, then MTC0 Status=0x0000_0F01 and hold irq[2]=1 with ex_valid=1 and ex_pc=0x40: exc_take one cycle after IP sampling; redirect_pc=0x180; all three flushes high; EPC=0x40, ExcCode=0, EXL=1.
- overflow=1 with int_req=1, ex_pc=0x88: ExcCode=12, EPC=0x88. A second overflow while EXL=1 leaves EPC=0x88 and redirects to 0x180 again.
- eret in HANDLER: IF_Flush only, redirect_pc=EPC, EXL=0 next cycle. eret together with overflow: exception vector wins and EXL stays 1.
- With CP0_TIMER_EN, Count=0xFFFF_FFFE, Compare=0xFFFF_FFFF:
  - IP7 sets two cycles later and Count wraps to 0.
  - MTC0 Compare clears IP7.
  - Without the macro, no IP7 ever sets.
- irq held with IE=0 or with ex_valid=0: no exc_take. Asserting reset mid-handler zeroes Status, Cause and EPC and drops all flushes in the same cycle.
